mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage with a stall FSM and the MEM/WB pipeline register.
// States: IDLE | no access in flight;  BUSY | counting stall cycles of a load/store
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [1:0]  ex_control_wb,
    input  logic [2:0]  ex_control_mem,
    input  logic        ex_zero,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_write_data,
    input  logic [4:0]  ex_write_reg,
    output logic        mem_stall,
    output logic        pcsrc,
    output logic [1:0]  mem_control_wb,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg,
    output logic        misaligned
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   mem [DEPTH];

    logic          branch, memread, memwrite;
    logic          mem_op, aligned, complete, wr_en, rd_en;
    logic [AW-1:0] idx;
    logic          unused_addr;

    assign {branch, memread, memwrite} = ex_control_mem;
    assign mem_op  = ex_valid & (memread | memwrite);
    assign aligned = (ex_alu_result[1:0] == 2'b00);
    assign idx     = ex_alu_result[AW+1:2];
    // Upper address bits are dropped so accesses wrap modulo DEPTH words.
    assign unused_addr = ^ex_alu_result[31:AW+2];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_stall = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && (MEM_LATENCY > 0)) begin
                    mem_stall = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(1);
                end else begin
                    complete = 1'b1;
                end
            end
            BUSY: begin
                if (cnt < CW'(MEM_LATENCY)) begin
                    mem_stall = 1'b1;
                    cnt_nxt   = cnt + CW'(1);
                end else begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign pcsrc = ex_valid & branch & ex_zero & ~mem_stall;

    // Gated with rst_n so an op abandoned by reset can never reach the array.
    assign wr_en = rst_n & complete & ex_valid & memwrite & aligned;
    assign rd_en = memread & ~memwrite & aligned;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= ex_write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_control_wb <= 2'b00;
            read_data      <= '0;
            mem_alu_result <= '0;
            mem_write_reg  <= '0;
            misaligned     <= 1'b0;
        end else if (complete && ex_valid) begin
            mem_control_wb <= ex_control_wb;
            read_data      <= rd_en ? mem[idx] : 32'h0;
            mem_alu_result <= ex_alu_result;
            mem_write_reg  <= ex_write_reg;
            misaligned     <= mem_op & ~aligned;
        end else begin
            mem_control_wb <= 2'b00;
            read_data      <= '0;
            mem_alu_result <= '0;
            mem_write_reg  <= '0;
            misaligned     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a latency-2 instance for the main flow and a latency-0 instance.
module tb_mem_stage;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [1:0]  ex_control_wb = 2'b00;
    logic [2:0]  ex_control_mem = 3'b000;
    logic        ex_zero = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_write_data = '0;
    logic [4:0]  ex_write_reg = '0;

    logic        mem_stall, pcsrc, misaligned;
    logic [1:0]  mem_control_wb;
    logic [31:0] read_data, mem_alu_result;
    logic [4:0]  mem_write_reg;

    logic        mem_stall0, pcsrc0, misaligned0;
    logic [1:0]  mem_control_wb0;
    logic [31:0] read_data0, mem_alu_result0;
    logic [4:0]  mem_write_reg0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        mis;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [256];

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(256), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_control_wb(ex_control_wb),
        .ex_control_mem(ex_control_mem), .ex_zero(ex_zero), .ex_alu_result(ex_alu_result),
        .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg), .mem_stall(mem_stall),
        .pcsrc(pcsrc), .mem_control_wb(mem_control_wb), .read_data(read_data),
        .mem_alu_result(mem_alu_result), .mem_write_reg(mem_write_reg), .misaligned(misaligned)
    );

    mem_stage #(.DEPTH(256), .MEM_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_control_wb(ex_control_wb),
        .ex_control_mem(ex_control_mem), .ex_zero(ex_zero), .ex_alu_result(ex_alu_result),
        .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg), .mem_stall(mem_stall0),
        .pcsrc(pcsrc0), .mem_control_wb(mem_control_wb0), .read_data(read_data0),
        .mem_alu_result(mem_alu_result0), .mem_write_reg(mem_write_reg0), .misaligned(misaligned0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctrl"}, 32'(mem_control_wb), 32'h0);
        chk({tag, "_rdata"}, read_data, 32'h0);
        chk({tag, "_alu"}, mem_alu_result, 32'h0);
        chk({tag, "_wreg"}, 32'(mem_write_reg), 32'h0);
        chk({tag, "_mis"}, 32'(misaligned), 32'h0);
    endtask

    task automatic drive(input logic v, input logic [1:0] cwb, input logic [2:0] cmem,
                         input logic z, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr);
        ex_valid       = v;
        ex_control_wb  = cwb;
        ex_control_mem = cmem;
        ex_zero        = z;
        ex_alu_result  = alu;
        ex_write_data  = wd;
        ex_write_reg   = wr;
    endtask

    // Called at posedge+1; returns at posedge+1 after the result edge.
    task automatic issue(input logic v, input logic [1:0] cwb, input logic [2:0] cmem,
                         input logic z, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr);
        exp_t       e;
        int         stalls;
        logic       mop, mis;
        logic [7:0] idx;
        drive(v, cwb, cmem, z, alu, wd, wr);
        mop    = v & (cmem[1] | cmem[0]);
        mis    = mop & (alu[1:0] != 2'b00);
        idx    = alu[9:2];
        e.ctrl  = v ? cwb : 2'b00;
        e.alu   = v ? alu : 32'h0;
        e.wreg  = v ? wr : 5'd0;
        e.mis   = mis;
        e.rdata = (v & cmem[1] & ~cmem[0] & ~mis) ? model[idx] : 32'h0;
        if (v & cmem[0] & ~mis) model[idx] = wd;
        sbq.push_back(e);
        stalls = 0;
        #1;
        while (mem_stall && stalls < 20) begin
            chk("pcsrc_in_stall", 32'(pcsrc), 32'h0);
            @(posedge clk);
            #1;
            stalls++;
            chk("bubble_ctrl", 32'(mem_control_wb), 32'h0);
        end
        chk("pcsrc", 32'(pcsrc), 32'(v & cmem[2] & z));
        chk("stall_cycles", 32'(stalls), mop ? 32'(LAT) : 32'h0);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_nonempty", 32'h0, 32'h1);
        end else begin
            e = sbq.pop_front();
            chk("ctrl", 32'(mem_control_wb), 32'(e.ctrl));
            chk("rdata", read_data, e.rdata);
            chk("alu", mem_alu_result, e.alu);
            chk("wreg", 32'(mem_write_reg), 32'(e.wreg));
            chk("mis", 32'(misaligned), 32'(e.mis));
        end
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("por");
        chk("por_stall", 32'(mem_stall), 32'h0);
        chk("por_pcsrc", 32'(pcsrc), 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type pass-through, then asynchronous reset mid-cycle
        issue(1'b1, 2'b10, 3'b000, 1'b0, 32'h1234, 32'h0, 5'd7);
        #2 rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        chk("async_rst_stall", 32'(mem_stall), 32'h0);
        chk("async_rst_pcsrc", 32'(pcsrc), 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Store then load
        issue(1'b1, 2'b00, 3'b001, 1'b0, 32'h40, 32'hDEADBEEF, 5'd0);
        issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h40, 32'h0, 5'd9);

        // Branches: taken, not taken, taken-but-stalled
        issue(1'b1, 2'b00, 3'b100, 1'b1, 32'h0, 32'h0, 5'd0);
        issue(1'b1, 2'b00, 3'b100, 1'b0, 32'h4, 32'h0, 5'd0);
        issue(1'b1, 2'b11, 3'b110, 1'b1, 32'h40, 32'h0, 5'd3);
        issue(1'b0, 2'b11, 3'b110, 1'b1, 32'h40, 32'h0, 5'd3);

        // Misaligned store suppressed, load unchanged, wrap, write-wins, misaligned load
        issue(1'b1, 2'b01, 3'b001, 1'b0, 32'h41, 32'h55, 5'd0);
        issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h40, 32'h0, 5'd4);
        issue(1'b1, 2'b00, 3'b001, 1'b0, 32'h400, 32'h0BADF00D, 5'd0);
        issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h0, 32'h0, 5'd5);
        issue(1'b1, 2'b11, 3'b011, 1'b0, 32'h8, 32'h13579BDF, 5'd6);
        issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h8, 32'h0, 5'd6);
        issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h42, 32'h0, 5'd8);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 2'b00, 3'b001, 1'b0, 32'h100 + 32'(i * 4), $urandom, 5'd0);
            issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 5'(i + 10));
        end

        // Reset during BUSY of a store abandons it
        issue(1'b1, 2'b00, 3'b001, 1'b0, 32'h80, 32'h11111111, 5'd0);
        drive(1'b1, 2'b00, 3'b001, 1'b0, 32'h80, 32'h22222222, 5'd0);
        @(posedge clk);
        #1;
        chk("busy_stall", 32'(mem_stall), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("busy_rst");
        drive(1'b0, 2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("busy_rst_stall", 32'(mem_stall), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h80, 32'h0, 5'd2);

        // Zero-latency instance: no stall, one-cycle results
        drive(1'b1, 2'b00, 3'b001, 1'b0, 32'h200, 32'hCAFEF00D, 5'd0);
        #1;
        chk("lat0_store_stall", 32'(mem_stall0), 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 2'b11, 3'b010, 1'b0, 32'h200, 32'h0, 5'd12);
        #1;
        chk("lat0_load_stall", 32'(mem_stall0), 32'h0);
        @(posedge clk);
        #1;
        chk("lat0_rdata", read_data0, 32'hCAFEF00D);
        chk("lat0_ctrl", 32'(mem_control_wb0), 32'h3);
        chk("lat0_alu", mem_alu_result0, 32'h200);
        chk("lat0_wreg", 32'(mem_write_reg0), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
